roll_button_conditioner: RTL and testbench
==========================================

// Module: roll_button_conditioner
// PURPOSE
//  Conditions the raw "roll" pushbutton before it reaches the dice roller.
//  Synchronizes and debounces the button, then emits exactly one clean 1-cycle
//  roll strobe per press. A post-release lockout blocks rapid re-triggers.
//  Keeps a running count of issued rolls. roll drives the roller's roll input directly.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive stable synced samples needed to change btn_level (>=2)
//  LOCKOUT_CYCLES   8   cycles after release during which new presses are ignored (>=1)
//  REPEAT_CYCLES    64  auto-repeat period in cycles; used only with ROLL_AUTOREPEAT_EN (>=2)
//  CNT_W            8   width of roll_count
// PORTS
//  clk         in   1      system clock, all logic on posedge
//  reset       in   1      asynchronous, active-high; clears all state
//  btn_raw     in   1      raw pushbutton, asynchronous to clk, 1 = pressed
//  enable      in   1      roll permission; 0 suppresses new roll strobes
//  roll        out  1      registered 1-cycle roll strobe to dice roller
//  btn_level   out  1      debounced button level
//  busy        out  1      1 while in PRESSED or LOCKOUT
//  roll_count  out  CNT_W  number of strobes issued, modulo 2^CNT_W
// BEHAVIOUR
//  Reset values: roll=0, btn_level=0, busy=0, roll_count=0.
//  Reset also clears: synchronizer flops, debounce counter, lockout counter, FSM=IDLE.
//  Sync: 2-flop synchronizer btn_raw -> s2.
//  Debounce, evaluated each edge:
//   - s2==btn_level: clear cnt.
//   - else if cnt==DEBOUNCE_CYCLES-1: btn_level<=s2, clear cnt.
//   - else: cnt++.
//   Pulses on s2 shorter than DEBOUNCE_CYCLES never change btn_level.
//  Latency: btn_raw rises (setup met) before edge 1 -> btn_level rises at edge
//   2+DEBOUNCE_CYCLES -> roll=1 from edge 3+DEBOUNCE_CYCLES for exactly 1 cycle.
//  FSM {IDLE, PRESSED, LOCKOUT}:
//   IDLE:    btn_level&&enable -> roll=1, roll_count++, go PRESSED.
//            btn_level&&!enable -> go PRESSED, no roll.
//   PRESSED: btn_level==0 -> load lkcnt=LOCKOUT_CYCLES, go LOCKOUT.
//            enable changes here have no effect.
//   LOCKOUT: lkcnt-- each cycle; btn_level is ignored (no roll).
//            At lkcnt==1: btn_level==0 -> IDLE; btn_level==1 -> PRESSED, no roll.
//   A new roll therefore always needs release + re-press.
//  busy is a registered decode of state, so it rises with roll.
//  roll_count wraps 2^CNT_W-1 -> 0 with no flag.
//  Reset mid-press: outputs drop asynchronously and no strobe is issued.
//   If the button is still held after reset deasserts, it is re-debounced and
//   rolls DEBOUNCE_CYCLES+3 edges later (treated as a fresh press).
// CONFIGURATION
//  ROLL_AUTOREPEAT_EN defined:
//   - In PRESSED, rpcnt counts up while btn_level==1.
//   - When rpcnt reaches REPEAT_CYCLES and enable==1: issue another roll,
//     roll_count++, clear rpcnt.
//   - If enable==0 at that point: rpcnt still clears, no roll.
//   - rpcnt clears on PRESSED entry.
//  Undefined: rpcnt logic is not built and REPEAT_CYCLES is unused.
//   Exactly one roll per press.
// TESTING (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8, REPEAT_CYCLES=10, CNT_W=2)
//  1. btn_raw 0->1 before edge 1, held 20 cycles.
//     -> btn_level=1 at edge 6; roll=1 only between edges 7 and 8.
//     -> roll_count=1; busy=1 from edge 7.
//  2. btn_raw high 3 cycles, low 2, then steady high.
//     -> the 3-cycle burst alone never raises btn_level; one roll total; roll_count=1.
//  3. Release then re-press so btn_level rises 3 cycles into LOCKOUT.
//     -> no roll; FSM goes to PRESSED at expiry with busy=1.
//     -> next roll only after release + lockout + re-press.
//  4. enable=0 during press -> no roll, roll_count unchanged.
//     Raising enable while still held -> still no roll.
//  5. Four clean presses -> roll_count 1,2,3,0 (wrap).
//  6. reset=1 asynchronously while PRESSED -> all outputs 0 before the next edge.
//     With ROLL_AUTOREPEAT_EN: hold 35 cycles past the first roll.
//     -> extra rolls 10, 20 and 30 cycles after it.

Source files
------------

// File: rtl/roll_button_conditioner.sv
// roll_button_conditioner
//   Turns the raw, bouncy "roll" pushbutton into exactly one clean 1-cycle roll
//   strobe per press. The button is synchronised and debounced first. A lockout
//   period after each release ignores rapid re-presses. The block also keeps a
//   running count of the strobes it has issued.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   reset      in   asynchronous active-high reset, clears all state
//   btn_raw    in   raw pushbutton (asynchronous to clk), 1 = pressed
//   enable     in   roll permission; 0 suppresses new roll strobes
//   roll       out  registered 1-cycle roll strobe to the dice roller
//   btn_level  out  debounced button level
//   busy       out  1 while the FSM is in PRESSED or LOCKOUT
//   roll_count out  number of strobes issued, modulo 2^CNT_W
//
// Configuration
//   ROLL_AUTOREPEAT_EN  when defined, a held button re-rolls every REPEAT_CYCLES
//                       cycles. When undefined, each press gives exactly one roll
//                       and REPEAT_CYCLES is unused.
module roll_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LOCKOUT_CYCLES  = 8,
  parameter int unsigned REPEAT_CYCLES   = 64,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_raw,
  input  logic             enable,
  output logic             roll,
  output logic             btn_level,
  output logic             busy,
  output logic [CNT_W-1:0] roll_count
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned LkW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LkW-1:0] LkLoad = LkW'(LOCKOUT_CYCLES);

  // Elaboration-time guard on the parameter ranges.
  if (DEBOUNCE_CYCLES < 2 || LOCKOUT_CYCLES < 1 || REPEAT_CYCLES < 2 || CNT_W < 1)
  begin : g_param_check
    $error("roll_button_conditioner: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StPressed, StLockout} state_e;

  logic             s1_q, s2_q;
  logic [DbW-1:0]   db_cnt_d, db_cnt_q;
  logic             btn_level_d, btn_level_q;
  state_e           state_d, state_q;
  logic [LkW-1:0]   lk_cnt_d, lk_cnt_q;
  logic             roll_d, roll_q;
  logic             busy_d, busy_q;
  logic [CNT_W-1:0] roll_count_d, roll_count_q;

`ifdef ROLL_AUTOREPEAT_EN
  localparam int unsigned RpW = $clog2(REPEAT_CYCLES);
  localparam logic [RpW-1:0] RpLast = RpW'(REPEAT_CYCLES - 1);
  logic [RpW-1:0] rp_cnt_d, rp_cnt_q;
`endif

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  // Debounce: btn_level follows s2 only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    db_cnt_d    = db_cnt_q;
    btn_level_d = btn_level_q;
    if (s2_q == btn_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbLast) begin
      btn_level_d = s2_q;
      db_cnt_d    = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Press FSM. A roll needs IDLE, so a press that matures during LOCKOUT parks
  // in PRESSED and has to be released and pressed again.
  always_comb begin
    state_d      = state_q;
    lk_cnt_d     = lk_cnt_q;
    roll_d       = 1'b0;
    roll_count_d = roll_count_q;
`ifdef ROLL_AUTOREPEAT_EN
    // Held at zero outside PRESSED, so it is already clear on PRESSED entry.
    rp_cnt_d     = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (btn_level_q) begin
          state_d = StPressed;
          if (enable) begin
            roll_d       = 1'b1;
            roll_count_d = roll_count_q + 1'b1;
          end
        end
      end
      StPressed: begin
        if (!btn_level_q) begin
          lk_cnt_d = LkLoad;
          state_d  = StLockout;
        end
`ifdef ROLL_AUTOREPEAT_EN
        else if (rp_cnt_q == RpLast) begin
          rp_cnt_d = '0;
          if (enable) begin
            roll_d       = 1'b1;
            roll_count_d = roll_count_q + 1'b1;
          end
        end else begin
          rp_cnt_d = rp_cnt_q + 1'b1;
        end
`endif
      end
      StLockout: begin
        if (lk_cnt_q == LkW'(1)) begin
          state_d = btn_level_q ? StPressed : StIdle;
        end else begin
          lk_cnt_d = lk_cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered from next state so busy rises in the same cycle as roll.
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q     <= '0;
      btn_level_q  <= 1'b0;
      state_q      <= StIdle;
      lk_cnt_q     <= '0;
      roll_q       <= 1'b0;
      busy_q       <= 1'b0;
      roll_count_q <= '0;
    end else begin
      db_cnt_q     <= db_cnt_d;
      btn_level_q  <= btn_level_d;
      state_q      <= state_d;
      lk_cnt_q     <= lk_cnt_d;
      roll_q       <= roll_d;
      busy_q       <= busy_d;
      roll_count_q <= roll_count_d;
    end
  end

`ifdef ROLL_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rp_cnt_q <= '0;
    end else begin
      rp_cnt_q <= rp_cnt_d;
    end
  end
`endif

  assign roll       = roll_q;
  assign btn_level  = btn_level_q;
  assign busy       = busy_q;
  assign roll_count = roll_count_q;

endmodule

// File: tb/tb_roll_button_conditioner.sv
// Testbench for roll_button_conditioner (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8,
// REPEAT_CYCLES=10, CNT_W=2). Stimulus pushes the expected (edge number, count)
// of every roll strobe into a queue; a monitor pops one entry per observed strobe.
module tb_roll_button_conditioner;

  logic       clk;
  logic       reset;
  logic       btn_raw;
  logic       enable;
  logic       roll;
  logic       btn_level;
  logic       busy;
  logic [1:0] roll_count;

  typedef struct {
    int at;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   tests  = 0;
  int   fails  = 0;
  int   exp_n  = 0;

  roll_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .LOCKOUT_CYCLES (8),
    .REPEAT_CYCLES  (10),
    .CNT_W          (2)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .enable    (enable),
    .roll      (roll),
    .btn_level (btn_level),
    .busy      (busy),
    .roll_count(roll_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc = number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expect one roll strobe visible right after edge 'at', with the next count.
  task automatic push(input int at);
    exp_t e;
    exp_n++;
    e.at  = at;
    e.cnt = exp_n % 4;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && roll) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_roll: got roll at edge %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("roll_edge", cyc, e.at);
        check("roll_count_at_roll", int'(roll_count), e.cnt);
      end
    end
  end

  initial begin
    int c;
    int r;
    reset   = 1'b1;
    btn_raw = 1'b0;
    enable  = 1'b1;
    tick(3);
    check("rst_roll", int'(roll), 0);
    check("rst_level", int'(btn_level), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(roll_count), 0);
    reset = 1'b0;
    tick(2);

    // 1: clean press, latency of btn_level, roll and busy.
    c = cyc;
    btn_raw = 1'b1;
    push(c + 7);
    tick(5);
    check("t1_level_early", int'(btn_level), 0);
    tick(1);
    check("t1_level_rise", int'(btn_level), 1);
    check("t1_busy_before_roll", int'(busy), 0);
    tick(1);
    check("t1_busy_with_roll", int'(busy), 1);
    tick(1);
    check("t1_roll_one_cycle", int'(roll), 0);
    tick(2);
    btn_raw = 1'b0;
    tick(20);
    check("t1_busy_idle", int'(busy), 0);
    check("t1_count", int'(roll_count), 1);

    // 2: 3-cycle burst is filtered, then a steady press rolls once.
    btn_raw = 1'b1;
    tick(3);
    btn_raw = 1'b0;
    tick(2);
    check("t2_burst_filtered", int'(btn_level), 0);
    c = cyc;
    btn_raw = 1'b1;
    push(c + 7);
    tick(5);
    check("t2_level_early", int'(btn_level), 0);
    tick(5);
    btn_raw = 1'b0;
    tick(20);
    check("t2_count", int'(roll_count), 2);

    // 3: re-press maturing 3 cycles into LOCKOUT gives no roll, parks in PRESSED.
    c = cyc;
    btn_raw = 1'b1;
    push(c + 7);
    tick(10);
    r = cyc;
    btn_raw = 1'b0;
    tick(4);
    btn_raw = 1'b1;
    tick(9);
    check("t3_level_in_lockout", int'(btn_level), 1);
    check("t3_busy_lockout", int'(busy), 1);
    tick(3);
    check("t3_busy_pressed", int'(busy), 1);
    btn_raw = 1'b0;
    tick(20);
    check("t3_busy_idle", int'(busy), 0);
    check("t3_count", int'(roll_count), 3);

    // 4: enable low at press, raised while held: no roll.
    enable = 1'b0;
    btn_raw = 1'b1;
    tick(8);
    check("t4_busy_no_roll", int'(busy), 1);
    enable = 1'b1;
    tick(2);
    btn_raw = 1'b0;
    tick(20);
    check("t4_count_unchanged", int'(roll_count), 3);
    check("t4_busy_idle", int'(busy), 0);

    // 5: four clean presses, counter wraps.
    for (int i = 0; i < 4; i++) begin
      c = cyc;
      btn_raw = 1'b1;
      push(c + 7);
      tick(10);
      btn_raw = 1'b0;
      tick(20);
      check("t5_count", int'(roll_count), exp_n % 4);
    end

    // 6: asynchronous reset while PRESSED, then re-debounce of the held button.
    c = cyc;
    btn_raw = 1'b1;
    push(c + 7);
    tick(9);
    #2 reset = 1'b1;
    #1;
    check("t6_async_roll", int'(roll), 0);
    check("t6_async_level", int'(btn_level), 0);
    check("t6_async_busy", int'(busy), 0);
    check("t6_async_count", int'(roll_count), 0);
    exp_n = 0;
    tick(2);
    reset = 1'b0;
    c = cyc;
    push(c + 7);
    tick(10);
    btn_raw = 1'b0;
    tick(20);
    check("t6_count_after_reset", int'(roll_count), 1);

`ifdef ROLL_AUTOREPEAT_EN
    // Auto-repeat: extra rolls 10, 20 and 30 cycles after the first.
    c = cyc;
    btn_raw = 1'b1;
    push(c + 7);
    push(c + 17);
    push(c + 27);
    push(c + 37);
    tick(40);
    btn_raw = 1'b0;
    tick(20);
    check("t7_count", int'(roll_count), exp_n % 4);
`endif

    tick(2);
    check("pending_rolls", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
